// File: rtl/parking_gate_controller_pkg.sv
// rtl/parking_gate_controller_pkg.sv - shared types and defaults for the parking gate controller
// Purpose: FSM state and direction encodings, registered-output bundle, default timing
//          constants and the vacancy lookup used by the IDLE arbitration.
// Ports: none (package).
package parking_gate_controller_pkg;

  localparam int PASS_TIMEOUT_DEF = 255;
  localparam int CLOSE_CYCLES_DEF = 16;
  localparam int TIMER_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  typedef enum logic {
    DIR_ENTRY = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  typedef struct packed {
    logic gate_open;
    logic entry_grant;
    logic exit_grant;
    logic entry_deny;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic timeout;
    logic busy;
  } lane_out_t;

  // Vacancy flag that applies to a car of the given class.
  function automatic logic has_space(input logic is_uni, input logic uni_vac, input logic pub_vac);
    return is_uni ? uni_vac : pub_vac;
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - lane request/response bundle between requesters and controller
// Purpose: groups the requester, counter-flag and sensor inputs with the barrier and
//          counter-pulse outputs of the controller.
// Ports: master = requester/counter/sensor side, slave = controller side.
interface parking_gate_controller_if;

  logic entry_req;
  logic entry_is_uni;
  logic exit_req;
  logic exit_is_uni;
  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic car_passed;

  logic gate_open;
  logic entry_grant;
  logic exit_grant;
  logic entry_deny;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;
  logic timeout;
  logic busy;

  modport master (
    output entry_req, entry_is_uni, exit_req, exit_is_uni,
           uni_is_vacated_space, is_vacated_space, car_passed,
    input  gate_open, entry_grant, exit_grant, entry_deny, car_entered,
           is_uni_car_entered, car_exited, is_uni_car_exited, timeout, busy
  );

  modport slave (
    input  entry_req, entry_is_uni, exit_req, exit_is_uni,
           uni_is_vacated_space, is_vacated_space, car_passed,
    output gate_open, entry_grant, exit_grant, entry_deny, car_entered,
           is_uni_car_entered, car_exited, is_uni_car_exited, timeout, busy
  );

endinterface

// File: rtl/parking_gate_controller_timer.sv
// rtl/parking_gate_controller_timer.sv - clear/enable up-counter with terminal-count compare
// Purpose: shared lane timer for the OPEN wait and the CLOSING hold.
// Ports: clk_i, rst_i (async, active-high), clr_i (to 0, wins over en_i), en_i (+1),
//        tc_val_i (terminal value), tc_o (count equals tc_val_i).
module parking_gate_controller_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [TIMER_W-1:0] tc_val_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - reversible barrier lane arbiter and passage sequencer
// Purpose: grants the lane to entry or exit, opens the barrier, waits for the pass
//          sensor, emits one count pulse per passage, then holds the lane while closing.
// Ports: clk_i, rst_i (async, active-high), lane_if (slave modport; requests, vacancy
//        flags and pass sensor in; barrier, grants, deny, count pulses, timeout, busy out).
module parking_gate_controller
  import parking_gate_controller_pkg::*;
#(
  parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF,
  parameter int TIMER_W      = TIMER_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  parking_gate_controller_if.slave lane_if
);

  state_t    state_q, state_d;
  dir_t      last_dir_q, last_dir_d;
  logic      uni_q, uni_d;
  lane_out_t out_q, out_d;

  logic deny_ev, timeout_ev;
  logic win_entry, win_exit, entry_space;
  logic tmr_clr, tmr_en, tmr_tc;
  logic [TIMER_W-1:0] tmr_tc_val;

  // When both sides wait, the side that did not use the lane last goes first.
  assign win_entry   = lane_if.entry_req && (!lane_if.exit_req || last_dir_q == DIR_EXIT);
  assign win_exit    = lane_if.exit_req && !win_entry;
  assign entry_space = has_space(lane_if.entry_is_uni, lane_if.uni_is_vacated_space,
                                 lane_if.is_vacated_space);

  // Every state change restarts the timer, so OPEN and CLOSING both start at 0.
  assign tmr_clr    = (state_d != state_q);
  assign tmr_en     = (state_q == ST_OPEN) || (state_q == ST_CLOSING);
  assign tmr_tc_val = (state_q == ST_CLOSING) ? TIMER_W'(CLOSE_CYCLES - 1)
                                              : TIMER_W'(PASS_TIMEOUT - 1);

  parking_gate_controller_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .tc_val_i (tmr_tc_val),
    .tc_o     (tmr_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      last_dir_q <= DIR_EXIT;
      uni_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      uni_q      <= uni_d;
      out_q      <= out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    uni_d      = uni_q;
    deny_ev    = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_entry && !entry_space) begin
          // Refused entry still counts as the entry turn so a waiting exit goes next.
          deny_ev    = 1'b1;
          last_dir_d = DIR_ENTRY;
        end else if (win_entry) begin
          state_d    = ST_OPEN;
          last_dir_d = DIR_ENTRY;
          uni_d      = lane_if.entry_is_uni;
        end else if (win_exit) begin
          state_d    = ST_OPEN;
          last_dir_d = DIR_EXIT;
          uni_d      = lane_if.exit_is_uni;
        end
      end
      ST_OPEN: begin
        // A pass on the expiry cycle still commits.
        if (lane_if.car_passed) begin
          state_d = ST_COMMIT;
        end else if (tmr_tc) begin
          state_d    = ST_CLOSING;
          timeout_ev = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_CLOSING;
      end
      ST_CLOSING: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    out_d                    = '0;
    out_d.gate_open          = (state_d == ST_OPEN);
    out_d.entry_grant        = (state_d == ST_OPEN) && (last_dir_d == DIR_ENTRY);
    out_d.exit_grant         = (state_d == ST_OPEN) && (last_dir_d == DIR_EXIT);
    out_d.entry_deny         = deny_ev;
    out_d.car_entered        = (state_d == ST_COMMIT) && (last_dir_d == DIR_ENTRY);
    out_d.is_uni_car_entered = (state_d == ST_COMMIT) && (last_dir_d == DIR_ENTRY) && uni_d;
    out_d.car_exited         = (state_d == ST_COMMIT) && (last_dir_d == DIR_EXIT);
    out_d.is_uni_car_exited  = (state_d == ST_COMMIT) && (last_dir_d == DIR_EXIT) && uni_d;
    out_d.timeout            = timeout_ev;
    out_d.busy               = (state_d != ST_IDLE);
  end

  assign lane_if.gate_open          = out_q.gate_open;
  assign lane_if.entry_grant        = out_q.entry_grant;
  assign lane_if.exit_grant         = out_q.exit_grant;
  assign lane_if.entry_deny         = out_q.entry_deny;
  assign lane_if.car_entered        = out_q.car_entered;
  assign lane_if.is_uni_car_entered = out_q.is_uni_car_entered;
  assign lane_if.car_exited         = out_q.car_exited;
  assign lane_if.is_uni_car_exited  = out_q.is_uni_car_exited;
  assign lane_if.timeout            = out_q.timeout;
  assign lane_if.busy               = out_q.busy;

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb/tb_parking_gate_controller.sv - directed self-checking bench for parking_gate_controller
module tb_parking_gate_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  parking_gate_controller_if lane_if();

  parking_gate_controller dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .lane_if (lane_if)
  );

  always #5 clk = ~clk;

  logic [9:0] outs;
  assign outs = {lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant, lane_if.entry_deny,
                 lane_if.car_entered, lane_if.is_uni_car_entered, lane_if.car_exited,
                 lane_if.is_uni_car_exited, lane_if.timeout, lane_if.busy};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    lane_if.entry_req            = 1'b0;
    lane_if.entry_is_uni         = 1'b0;
    lane_if.exit_req             = 1'b0;
    lane_if.exit_is_uni          = 1'b0;
    lane_if.uni_is_vacated_space = 1'b0;
    lane_if.is_vacated_space     = 1'b0;
    lane_if.car_passed           = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pass_car();
    lane_if.car_passed = 1'b1;
    tick();
    lane_if.car_passed = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL reset_outs_asserted: got %b expected %b", outs, 10'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL reset_outs_idle: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_entry_basic();
    do_reset();
    lane_if.is_vacated_space = 1'b1;
    lane_if.entry_req        = 1'b1;
    lane_if.entry_is_uni     = 1'b0;
    tick();
    checks++;
    if ({lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant, lane_if.busy} !== 4'b1101) begin
      failures++;
      $display("FAIL entry_grant_latency: got %b expected %b",
               {lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant, lane_if.busy}, 4'b1101);
    end
    lane_if.entry_req = 1'b0;
    repeat (4) tick();
    pass_car();
    checks++;
    if ({lane_if.car_entered, lane_if.is_uni_car_entered, lane_if.car_exited,
         lane_if.gate_open, lane_if.entry_grant} !== 5'b10000) begin
      failures++;
      $display("FAIL entry_commit: got %b expected %b",
               {lane_if.car_entered, lane_if.is_uni_car_entered, lane_if.car_exited,
                lane_if.gate_open, lane_if.entry_grant}, 5'b10000);
    end
    tick();
    checks++;
    if ({lane_if.car_entered, lane_if.busy} !== 2'b01) begin
      failures++;
      $display("FAIL entry_pulse_width: got %b expected %b", {lane_if.car_entered, lane_if.busy}, 2'b01);
    end
    repeat (15) tick();
    checks++;
    if (lane_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_last_close_cycle: got %b expected %b", lane_if.busy, 1'b1);
    end
    tick();
    checks++;
    if (lane_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_clear_after_close: got %b expected %b", lane_if.busy, 1'b0);
    end
  endtask

  task automatic test_alternate();
    logic exp_e;
    do_reset();
    lane_if.is_vacated_space     = 1'b0;
    lane_if.uni_is_vacated_space = 1'b1;
    lane_if.entry_is_uni         = 1'b1;
    lane_if.exit_is_uni          = 1'b0;
    lane_if.entry_req            = 1'b1;
    lane_if.exit_req             = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      exp_e = (r % 2 == 0);
      checks++;
      if ({lane_if.entry_grant, lane_if.exit_grant} !== {exp_e, !exp_e}) begin
        failures++;
        $display("FAIL alt_grant round %0d: got %b expected %b", r,
                 {lane_if.entry_grant, lane_if.exit_grant}, {exp_e, !exp_e});
      end
      pass_car();
      checks++;
      if ({lane_if.car_entered, lane_if.is_uni_car_entered, lane_if.car_exited,
           lane_if.is_uni_car_exited} !== {exp_e, exp_e, !exp_e, 1'b0}) begin
        failures++;
        $display("FAIL alt_count round %0d: got %b expected %b", r,
                 {lane_if.car_entered, lane_if.is_uni_car_entered, lane_if.car_exited,
                  lane_if.is_uni_car_exited}, {exp_e, exp_e, !exp_e, 1'b0});
      end
      repeat (17) tick();
      checks++;
      if ({lane_if.busy, lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant} !== 4'b0000) begin
        failures++;
        $display("FAIL alt_turnaround round %0d: got %b expected %b", r,
                 {lane_if.busy, lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant}, 4'b0000);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_deny();
    do_reset();
    lane_if.is_vacated_space     = 1'b1;
    lane_if.uni_is_vacated_space = 1'b0;
    lane_if.entry_req            = 1'b1;
    lane_if.entry_is_uni         = 1'b1;
    lane_if.exit_req             = 1'b1;
    lane_if.exit_is_uni          = 1'b1;
    tick();
    checks++;
    if ({lane_if.entry_deny, lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant,
         lane_if.busy} !== 5'b10000) begin
      failures++;
      $display("FAIL deny_pulse: got %b expected %b",
               {lane_if.entry_deny, lane_if.gate_open, lane_if.entry_grant, lane_if.exit_grant,
                lane_if.busy}, 5'b10000);
    end
    lane_if.entry_req = 1'b0;
    tick();
    checks++;
    if ({lane_if.entry_deny, lane_if.gate_open, lane_if.exit_grant, lane_if.entry_grant} !== 4'b0110) begin
      failures++;
      $display("FAIL deny_then_exit: got %b expected %b",
               {lane_if.entry_deny, lane_if.gate_open, lane_if.exit_grant, lane_if.entry_grant}, 4'b0110);
    end
    lane_if.exit_req = 1'b0;
    pass_car();
    checks++;
    if ({lane_if.car_entered, lane_if.car_exited, lane_if.is_uni_car_exited} !== 3'b011) begin
      failures++;
      $display("FAIL deny_exit_commit: got %b expected %b",
               {lane_if.car_entered, lane_if.car_exited, lane_if.is_uni_car_exited}, 3'b011);
    end
    repeat (20) tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    lane_if.exit_req    = 1'b1;
    lane_if.exit_is_uni = 1'b0;
    tick();
    checks++;
    if (lane_if.exit_grant !== 1'b1) begin
      failures++;
      $display("FAIL timeout_grant: got %b expected %b", lane_if.exit_grant, 1'b1);
    end
    lane_if.exit_req = 1'b0;
    repeat (254) begin
      tick();
      if (lane_if.timeout !== 1'b0 || lane_if.gate_open !== 1'b1) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL timeout_early: got %0d bad cycles expected %0d", early, 0);
    end
    tick();
    checks++;
    if ({lane_if.timeout, lane_if.gate_open, lane_if.exit_grant, lane_if.car_exited,
         lane_if.busy} !== 5'b10001) begin
      failures++;
      $display("FAIL timeout_pulse: got %b expected %b",
               {lane_if.timeout, lane_if.gate_open, lane_if.exit_grant, lane_if.car_exited,
                lane_if.busy}, 5'b10001);
    end
    tick();
    checks++;
    if (lane_if.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_width: got %b expected %b", lane_if.timeout, 1'b0);
    end
    pass_car();
    checks++;
    if ({lane_if.car_entered, lane_if.car_exited, lane_if.busy} !== 3'b001) begin
      failures++;
      $display("FAIL pass_in_closing: got %b expected %b",
               {lane_if.car_entered, lane_if.car_exited, lane_if.busy}, 3'b001);
    end
    repeat (20) tick();
    checks++;
    if (lane_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_close_done: got %b expected %b", lane_if.busy, 1'b0);
    end
  endtask

  task automatic test_pass_on_expiry();
    do_reset();
    lane_if.exit_req = 1'b1;
    tick();
    lane_if.exit_req = 1'b0;
    repeat (254) tick();
    pass_car();
    checks++;
    if ({lane_if.car_exited, lane_if.timeout} !== 2'b10) begin
      failures++;
      $display("FAIL pass_on_expiry: got %b expected %b", {lane_if.car_exited, lane_if.timeout}, 2'b10);
    end
    tick();
    checks++;
    if ({lane_if.car_exited, lane_if.timeout} !== 2'b00) begin
      failures++;
      $display("FAIL pass_on_expiry_after: got %b expected %b",
               {lane_if.car_exited, lane_if.timeout}, 2'b00);
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    lane_if.is_vacated_space = 1'b1;
    lane_if.entry_req        = 1'b1;
    tick();
    lane_if.entry_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (lane_if.gate_open !== 1'b1) begin
      failures++;
      $display("FAIL mid_open_precondition: got %b expected %b", lane_if.gate_open, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL async_reset_outs: got %b expected %b", outs, 10'b0);
    end
    tick();
    rst = 1'b0;
    tick();
    pass_car();
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL late_pass_after_reset: got %b expected %b", outs, 10'b0);
    end
    repeat (3) tick();
    checks++;
    if (outs !== 10'b0) begin
      failures++;
      $display("FAIL no_deferred_commit: got %b expected %b", outs, 10'b0);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_entry_basic();
    test_alternate();
    test_deny();
    test_timeout();
    test_pass_on_expiry();
    test_reset_mid_open();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
